tmr_clk_sel_cnt: RTL and testbench
==================================

Name: tmr_clk_sel_cnt

Overview:
Timer counting core that directly consumes the four divided clocks, clk_in[3:0] (div2/4/8/16 of sys_clk).
- Selects one divided clock and synchronizes it into the sys_clk domain.
- Turns each rising edge of the selected clock into a one-cycle count tick.
- Drives an 8-bit up/down counter with parallel load and overflow/underflow pulses.
- Sits between the clock-divider stage and the timer register/interrupt logic.

Parameters:
- CNT_W, 8: counter and load-data width.
- GUARD_CYC, 3: number of sys_clk cycles that ticks are masked after reset or a clock-select change.

Ports:
- sys_clk  input  1  system clock; all flops on its posedge.
- sys_rst_n  input  1  synchronous, active-low reset, sampled on posedge sys_clk.
- clk_in  input  4  divided clocks {div16, div8, div4, div2}; asynchronous to the logic, treated as data.
- cks  input  2  clock select: 0=div2, 1=div4, 2=div8, 3=div16.
- en  input  1  count enable.
- up_dn  input  1  direction: 1=up, 0=down.
- load  input  1  synchronous parallel load.
- tdr  input  CNT_W  load data.
- cnt  output  CNT_W  current count (registered).
- tick  output  1  registered pulse: a selected-clock rising edge was accepted this cycle.
- tmr_ovf  output  1  one-cycle overflow pulse (registered).
- tmr_udf  output  1  one-cycle underflow pulse (registered).

Behaviour:
- Reset (sys_rst_n=0 at posedge) sets:
  - cnt=0, tick=0, tmr_ovf=0, tmr_udf=0;
  - sync1, sync2 and prev = 0;
  - cks_q=0;
  - guard=GUARD_CYC.
- Reset mid-count aborts immediately. No pulse is issued on the reset edge.
- Selection: sel = clk_in[cks], using live cks.
- Synchronizer: sync1<=sel, sync2<=sync1, prev<=sync2, every cycle regardless of en.
- Edge: raw_edge = sync2 & ~prev & (guard==0).
- Latency: if clk_in[cks] is first sampled high at posedge k, raw_edge is high during cycle k+1..k+2, and cnt/tick/flags update at posedge k+2.
- Guard:
  - If cks != cks_q: cks_q<=cks and guard<=GUARD_CYC.
  - Otherwise guard decrements to 0 and saturates.
  - Result: no false tick from the mux switching.
- Counter update priority at each posedge:
  1. load=1: cnt<=tdr; tick, ovf and udf are 0. Applies regardless of en or raw_edge.
  2. en=1 and raw_edge=1, up_dn=1: cnt<=cnt+1. On 0xFF->0x00 wrap, tmr_ovf=1 for one cycle.
  3. en=1 and raw_edge=1, up_dn=0: cnt<=cnt-1. On 0x00->0xFF wrap, tmr_udf=1 for one cycle.
  4. Otherwise cnt holds; tick, ovf and udf return to 0.
- tick=1 only in cases 2 and 3.
- Edges arriving while en=0 or load=1 are dropped, not queued.
- Arithmetic is modulo 2^CNT_W with no saturation. Changing up_dn between ticks takes effect on the next tick.
- Tick rate at steady state: one tick per 2/4/8/16 sys_clk cycles for cks=0/1/2/3.

Optional Feature:
- Macro: TMR_CMP_EN.
- When defined:
  - Adds input tcmp[CNT_W-1:0] and output cmp_match (1 bit).
  - cmp_match is a registered one-cycle pulse, asserted on the same edge on which a tick (case 2 or 3) updates cnt to a value equal to tcmp.
  - A load that equals tcmp does not assert it.
  - cmp_match resets to 0.
- When undefined: neither port exists and no compare logic is built.

Test Plan:
- Reset release, cks=0, en=1, up_dn=1: cnt stays 0 for the first GUARD_CYC cycles, then increments once every 2 sys_clk cycles (0,1,2,...) with a tick pulse per increment.
- load=1, tdr=0xFE, then cks=1, en=1, up: cnt goes 0xFE -> 0xFF -> 0x00 at 4-cycle spacing; tmr_ovf is high for exactly the one cycle cnt becomes 0x00.
- load tdr=0x01, cks=3, up_dn=0: cnt goes 0x01 -> 0x00 -> 0xFF at 16-cycle spacing; tmr_udf pulses once, when cnt becomes 0xFF.
- Switch cks from 0 to 3 while counting: no tick within GUARD_CYC cycles of the switch; afterwards ticks every 16 cycles; no double count at the transition.
- Assert load=1 (tdr=0x55) on the same cycle raw_edge=1, en=1: cnt=0x55, tick=0. Then drop en: cnt holds 0x55 across 3 selected-clock edges.
- TMR_CMP_EN defined, tcmp=0x03, count up from 0: cmp_match pulses once, when cnt becomes 0x03. A load of 0x03 produces no pulse.
- Assert sys_rst_n=0 mid-count at cnt=0x7A: next posedge gives cnt=0, with all pulses low.

Source files
------------

// File: rtl/tmr_clk_sel_cnt.sv
`default_nettype none
// ============================================================================
// Module  : tmr_clk_sel_cnt
// Brief   : Selects one of four divided clocks, synchronizes it to sys_clk and
//           counts its rising edges with an up/down counter with parallel load.
//           Optional compare output enabled by macro TMR_CMP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tmr_clk_sel_cnt #(
    parameter int CNT_W     = 8,
    parameter int GUARD_CYC = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [3:0]       clk_in,
    input  logic [1:0]       cks,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [CNT_W-1:0] tdr,
`ifdef TMR_CMP_EN
    input  logic [CNT_W-1:0] tcmp,
    output logic             cmp_match,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             tick,
    output logic             tmr_ovf,
    output logic             tmr_udf
);

    localparam int               c_GW         = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);
    localparam logic [c_GW-1:0]  c_GUARD_INIT = c_GW'(GUARD_CYC);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [1:0]       r_cks_q;
    logic [c_GW-1:0]  r_guard;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_ovf;
    logic             r_udf;

    logic             w_sel;
    logic             w_raw_edge;
    logic             w_step;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_sel      = clk_in[cks];
    assign w_raw_edge = r_sync2 & ~r_prev & (r_guard == '0);
    assign w_step     = en & w_raw_edge & ~load;
    assign w_cnt_nxt  = up_dn ? (r_cnt + c_CNT_ONE) : (r_cnt - c_CNT_ONE);

    // The guard window hides the glitch the mux can produce when cks changes.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_cks_q <= 2'd0;
            r_guard <= c_GUARD_INIT;
        end else begin
            r_sync1 <= w_sel;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (cks != r_cks_q) begin
                r_cks_q <= cks;
                r_guard <= c_GUARD_INIT;
            end else if (r_guard != '0) begin
                r_guard <= r_guard - c_GW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else if (load) begin
            r_cnt  <= tdr;
            r_tick <= 1'b0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else if (w_step) begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= 1'b1;
            r_ovf  <= up_dn & (r_cnt == c_CNT_MAX);
            r_udf  <= ~up_dn & (r_cnt == '0);
        end else begin
            r_tick <= 1'b0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end
    end

`ifdef TMR_CMP_EN
    logic r_cmp_match;

    // Only counted values match; a load landing on tcmp stays silent.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_cmp_match <= 1'b0;
        end else begin
            r_cmp_match <= w_step & (w_cnt_nxt == tcmp);
        end
    end

    assign cmp_match = r_cmp_match;
`endif

    assign cnt     = r_cnt;
    assign tick    = r_tick;
    assign tmr_ovf = r_ovf;
    assign tmr_udf = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_tmr_clk_sel_cnt.sv
`default_nettype none
// Testbench for tmr_clk_sel_cnt: directed scenarios plus random stimulus
// checked cycle by cycle against an edge-history reference model.
module tb_tmr_clk_sel_cnt;
    localparam int CNT_W     = 8;
    localparam int GUARD_CYC = 3;
    localparam int c_MOD     = 1 << CNT_W;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [3:0]       div_cnt   = 4'd0;
    logic [3:0]       clk_in;
    logic [1:0]       cks       = 2'd0;
    logic             en        = 1'b0;
    logic             up_dn     = 1'b1;
    logic             load      = 1'b0;
    logic [CNT_W-1:0] tdr       = '0;
    wire  [CNT_W-1:0] cnt;
    wire              tick;
    wire              tmr_ovf;
    wire              tmr_udf;
    wire              w_cmp;
`ifdef TMR_CMP_EN
    logic [CNT_W-1:0] tcmp      = '0;
    wire              cmp_match;
    assign w_cmp = cmp_match;
`else
    assign w_cmp = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;
    always @(negedge sys_clk) div_cnt <= div_cnt + 4'd1;
    assign clk_in = div_cnt;

    tmr_clk_sel_cnt #(.CNT_W(CNT_W), .GUARD_CYC(GUARD_CYC)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .clk_in   (clk_in),
        .cks      (cks),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .tdr      (tdr),
`ifdef TMR_CMP_EN
        .tcmp     (tcmp),
        .cmp_match(cmp_match),
`endif
        .cnt      (cnt),
        .tick     (tick),
        .tmr_ovf  (tmr_ovf),
        .tmr_udf  (tmr_udf)
    );

    wire [CNT_W+3:0] dut_v = {cnt, tick, tmr_ovf, tmr_udf, w_cmp};

    // Reference model: selected-clock level history indexed by posedge number.
    int               cyc      = 0;
    bit               sel_hist[$];
    int               last_evt = 0;
    logic [1:0]       m_cks    = 2'd0;
    logic [CNT_W-1:0] m_cnt    = '0;
    bit               m_tick, m_ovf, m_udf, m_cmp;
    logic [CNT_W+3:0] exp_v    = '0;

    task automatic step();
        int t;
        int nv;
        bit rise;
        @(posedge sys_clk);
        t = cyc;
        sel_hist.push_back(clk_in[cks]);
        if (!sys_rst_n) begin
            last_evt = t;
            m_cks    = 2'd0;
            m_cnt    = '0;
            {m_tick, m_ovf, m_udf, m_cmp} = 4'b0;
        end else begin
            // A rising edge seen two samples ago is accepted once the guard window has passed.
            rise = (t - last_evt > GUARD_CYC) && sel_hist[t-2] && !sel_hist[t-3];
            if (cks != m_cks) begin
                m_cks    = cks;
                last_evt = t;
            end
            {m_tick, m_ovf, m_udf, m_cmp} = 4'b0;
            if (load) begin
                m_cnt = tdr;
            end else if (en && rise) begin
                nv     = up_dn ? int'(m_cnt) + 1 : int'(m_cnt) - 1;
                m_ovf  = (nv >= c_MOD);
                m_udf  = (nv < 0);
                m_cnt  = CNT_W'((nv + c_MOD) % c_MOD);
                m_tick = 1'b1;
`ifdef TMR_CMP_EN
                m_cmp  = (m_cnt == tcmp);
`endif
            end
        end
        exp_v = {m_cnt, m_tick, m_ovf, m_udf, m_cmp};
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; cks = 2'd0; load = 1'b0;
        repeat (3) begin
            step();
            n_vec++;
            if (dut_v !== exp_v) begin n_err++; $display("FAIL reset_model cyc=%0d: dut=%h model=%h", cyc, dut_v, exp_v); end
        end
        n_vec++;
        if ({cnt, tick, tmr_ovf, tmr_udf, w_cmp} !== '0) begin
            n_err++; $display("FAIL reset_state: dut=%h want 0", dut_v);
        end
    endtask

    task automatic test_count_up();
        int last_t = -1;
        int nticks = 0;
        sys_rst_n = 1'b1;
        for (int i = 0; i < GUARD_CYC; i++) begin
            step();
            n_vec++;
            if (cnt !== '0 || tick !== 1'b0) begin n_err++; $display("FAIL guard_hold: cnt=%h tick=%b want 00/0", cnt, tick); end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++;
            if (dut_v !== exp_v) begin n_err++; $display("FAIL count_up_model cyc=%0d: dut=%h model=%h", cyc, dut_v, exp_v); end
            if (tick) begin
                nticks++;
                if (last_t >= 0 && cyc - last_t != 2) begin
                    n_err++; $display("FAIL div2_spacing: got %0d want 2", cyc - last_t);
                end
                last_t = cyc;
                n_vec++;
                if (cnt !== CNT_W'(nticks)) begin n_err++; $display("FAIL count_up_value: cnt=%h want %h", cnt, CNT_W'(nticks)); end
            end
        end
    endtask

    task automatic test_ovf();
        int t_ff = -1, t_00 = -1, n_ovf = 0;
        load = 1'b1; tdr = 8'hFE; cks = 2'd1; en = 1'b1; up_dn = 1'b1;
        step();
        n_vec++;
        if (cnt !== 8'hFE || tick !== 1'b0) begin n_err++; $display("FAIL ovf_load: cnt=%h tick=%b want FE/0", cnt, tick); end
        load = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            n_vec++;
            if (dut_v !== exp_v) begin n_err++; $display("FAIL ovf_model cyc=%0d: dut=%h model=%h", cyc, dut_v, exp_v); end
            if (tick && cnt == 8'hFF && t_ff < 0) t_ff = cyc;
            if (tick && cnt == 8'h00 && t_00 < 0) t_00 = cyc;
            if (tmr_ovf) begin
                n_ovf++;
                if (cnt !== 8'h00) begin n_err++; $display("FAIL ovf_at_zero: cnt=%h want 00", cnt); end
            end
        end
        n_vec++;
        if (t_ff < 0 || t_00 < 0 || t_00 - t_ff != 4) begin n_err++; $display("FAIL ovf_spacing: got %0d want 4", t_00 - t_ff); end
        n_vec++;
        if (n_ovf != 1) begin n_err++; $display("FAIL ovf_count: got %0d want 1", n_ovf); end
    endtask

    task automatic test_udf();
        int t_00 = -1, t_ff = -1, n_udf = 0;
        load = 1'b1; tdr = 8'h01; cks = 2'd3; up_dn = 1'b0; en = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            n_vec++;
            if (dut_v !== exp_v) begin n_err++; $display("FAIL udf_model cyc=%0d: dut=%h model=%h", cyc, dut_v, exp_v); end
            if (tick && cnt == 8'h00 && t_00 < 0) t_00 = cyc;
            if (tick && cnt == 8'hFF && t_ff < 0) t_ff = cyc;
            if (tmr_udf) begin
                n_udf++;
                if (cnt !== 8'hFF) begin n_err++; $display("FAIL udf_at_ff: cnt=%h want FF", cnt); end
            end
        end
        n_vec++;
        if (t_00 < 0 || t_ff < 0 || t_ff - t_00 != 16) begin n_err++; $display("FAIL udf_spacing: got %0d want 16", t_ff - t_00); end
        n_vec++;
        if (n_udf != 1) begin n_err++; $display("FAIL udf_count: got %0d want 1", n_udf); end
    endtask

    task automatic test_switch();
        int last_t = -1;
        load = 1'b1; tdr = 8'h00; cks = 2'd0; up_dn = 1'b1; en = 1'b1;
        step();
        load = 1'b0;
        repeat (10) step();
        cks = 2'd3;
        step();
        n_vec++;
        if (dut_v !== exp_v) begin n_err++; $display("FAIL switch_edge_model: dut=%h model=%h", dut_v, exp_v); end
        for (int i = 0; i < GUARD_CYC; i++) begin
            step();
            n_vec++;
            if (tick !== 1'b0) begin n_err++; $display("FAIL switch_guard: tick=%b want 0", tick); end
        end
        for (int i = 0; i < 60; i++) begin
            step();
            n_vec++;
            if (dut_v !== exp_v) begin n_err++; $display("FAIL switch_model cyc=%0d: dut=%h model=%h", cyc, dut_v, exp_v); end
            if (tick) begin
                if (last_t >= 0 && cyc - last_t != 16) begin
                    n_err++; $display("FAIL div16_spacing: got %0d want 16", cyc - last_t);
                end
                last_t = cyc;
            end
        end
    endtask

    task automatic test_load_edge();
        int budget = 0;
        cks = 2'd0; en = 1'b1; up_dn = 1'b1;
        step();
        while (!tick && budget < 20) begin step(); budget++; end
        n_vec++;
        if (!tick) begin n_err++; $display("FAIL load_edge_tick_timeout: tick=%b want 1", tick); end
        step();
        load = 1'b1; tdr = 8'h55;
        step();
        n_vec++;
        if (cnt !== 8'h55 || tick !== 1'b0) begin n_err++; $display("FAIL load_priority: cnt=%h tick=%b want 55/0", cnt, tick); end
        load = 1'b0; en = 1'b0;
        repeat (6) begin
            step();
            n_vec++;
            if (cnt !== 8'h55 || tick !== 1'b0) begin n_err++; $display("FAIL en_hold: cnt=%h tick=%b want 55/0", cnt, tick); end
        end
    endtask

`ifdef TMR_CMP_EN
    task automatic test_cmp();
        int n_cmp = 0;
        tcmp = 8'h03; load = 1'b1; tdr = 8'h00; cks = 2'd0; en = 1'b1; up_dn = 1'b1;
        step();
        load = 1'b0;
        repeat (14) begin
            step();
            n_vec++;
            if (dut_v !== exp_v) begin n_err++; $display("FAIL cmp_model cyc=%0d: dut=%h model=%h", cyc, dut_v, exp_v); end
            if (cmp_match) begin
                n_cmp++;
                if (cnt !== 8'h03) begin n_err++; $display("FAIL cmp_value: cnt=%h want 03", cnt); end
            end
        end
        n_vec++;
        if (n_cmp != 1) begin n_err++; $display("FAIL cmp_count: got %0d want 1", n_cmp); end
        load = 1'b1; tdr = 8'h03;
        step();
        n_vec++;
        if (cmp_match !== 1'b0 || cnt !== 8'h03) begin n_err++; $display("FAIL cmp_on_load: cmp=%b cnt=%h want 0/03", cmp_match, cnt); end
        load = 1'b0;
    endtask
`endif

    task automatic test_mid_reset();
        int budget = 0;
        load = 1'b1; tdr = 8'h78; cks = 2'd0; en = 1'b1; up_dn = 1'b1;
        step();
        load = 1'b0;
        while (cnt != 8'h7A && budget < 30) begin step(); budget++; end
        n_vec++;
        if (cnt !== 8'h7A) begin n_err++; $display("FAIL mid_reset_reach: cnt=%h want 7A", cnt); end
        sys_rst_n = 1'b0;
        step();
        n_vec++;
        if ({cnt, tick, tmr_ovf, tmr_udf, w_cmp} !== '0) begin n_err++; $display("FAIL mid_reset: dut=%h want 0", dut_v); end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) cks = 2'($urandom_range(0, 3));
            load  = ($urandom_range(0, 15) == 0);
            tdr   = CNT_W'($urandom);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) up_dn = ~up_dn;
            sys_rst_n = ($urandom_range(0, 199) != 0);
`ifdef TMR_CMP_EN
            if ($urandom_range(0, 19) == 0) tcmp = CNT_W'($urandom);
`endif
            step();
            n_vec++;
            if (dut_v !== exp_v) begin n_err++; $display("FAIL random_model cyc=%0d: dut=%h model=%h", cyc, dut_v, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_ovf();
        test_udf();
        test_switch();
        test_load_edge();
`ifdef TMR_CMP_EN
        test_cmp();
`endif
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
